// File: rtl/seq_gen_sft.sv
// rtl/seq_gen_sft.sv - serial pattern transmitter with repeat count and idle gap
module seq_gen_sft #(
    parameter int              WIDTH   = 6,
    parameter logic [WIDTH-1:0] PATTERN = 6'b100110,
    parameter int              CNT_W   = 4,
    parameter int              GAP_W   = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_vld,
    output logic             load_rdy,
    input  logic             load_def,
    input  logic [WIDTH-1:0] load_pat,
    input  logic [CNT_W-1:0] load_rpt,
    input  logic [GAP_W-1:0] load_gap,
    input  logic             abort,
    output logic             dout,
    output logic             dout_vld,
    output logic             busy,
    output logic             frame_done,
    output logic             all_done
);

    localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [BW-1:0]    LAST  = BW'(WIDTH - 1);
    localparam logic [BW-1:0]    BIT1  = BW'(1);
    localparam logic [CNT_W-1:0] CNT1  = CNT_W'(1);
    localparam logic [GAP_W-1:0] GAP1  = GAP_W'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SEND = 2'd1,
        S_GAP  = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] shreg;     // bits still to be shifted out of the current frame
    logic [WIDTH-1:0] pat_lat;   // job pattern, reloaded at the start of every frame
    logic [BW-1:0]    bit_cnt;   // index of the bit currently on dout
    logic [CNT_W-1:0] frm_cnt;   // frames remaining after the current one
    logic [GAP_W-1:0] gap_len;   // latched idle-gap length
    logic [GAP_W-1:0] gap_cnt;   // gap cycles remaining after the current one

    logic [WIDTH-1:0] load_word;

    assign load_word = load_def ? PATTERN : load_pat;
    assign load_rdy  = (state == S_IDLE);

    // Job FSM: all outputs registered so they line up with the bit on dout
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            shreg      <= '0;
            pat_lat    <= '0;
            bit_cnt    <= '0;
            frm_cnt    <= '0;
            gap_len    <= '0;
            gap_cnt    <= '0;
            dout       <= 1'b0;
            dout_vld   <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            all_done   <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            all_done   <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (load_vld) begin
                        pat_lat  <= load_word;
                        shreg    <= load_word << 1;
                        frm_cnt  <= load_rpt;
                        gap_len  <= load_gap;
                        bit_cnt  <= '0;
                        dout     <= load_word[WIDTH-1];
                        dout_vld <= 1'b1;
                        busy     <= 1'b1;
                        state    <= S_SEND;
                    end
                end
                S_SEND: begin
                    if (abort) begin
                        dout     <= 1'b0;
                        dout_vld <= 1'b0;
                        busy     <= 1'b0;
                        state    <= S_IDLE;
                    end else if (bit_cnt == LAST) begin
                        if (frm_cnt == '0) begin
                            dout     <= 1'b0;
                            dout_vld <= 1'b0;
                            busy     <= 1'b0;
                            state    <= S_IDLE;
                        end else begin
                            frm_cnt <= frm_cnt - CNT1;
                            if (gap_len == '0) begin
                                shreg    <= pat_lat << 1;
                                bit_cnt  <= '0;
                                dout     <= pat_lat[WIDTH-1];
                                dout_vld <= 1'b1;
                            end else begin
                                gap_cnt  <= gap_len - GAP1;
                                dout     <= 1'b0;
                                dout_vld <= 1'b0;
                                state    <= S_GAP;
                            end
                        end
                    end else begin
                        dout    <= shreg[WIDTH-1];
                        shreg   <= shreg << 1;
                        bit_cnt <= bit_cnt + BIT1;
                        if ((bit_cnt + BIT1) == LAST) begin
                            frame_done <= 1'b1;
                            all_done   <= (frm_cnt == '0);
                        end
                    end
                end
                S_GAP: begin
                    if (abort) begin
                        dout     <= 1'b0;
                        dout_vld <= 1'b0;
                        busy     <= 1'b0;
                        state    <= S_IDLE;
                    end else if (gap_cnt == '0) begin
                        shreg    <= pat_lat << 1;
                        bit_cnt  <= '0;
                        dout     <= pat_lat[WIDTH-1];
                        dout_vld <= 1'b1;
                        state    <= S_SEND;
                    end else begin
                        gap_cnt <= gap_cnt - GAP1;
                    end
                end
                default: begin
                    dout     <= 1'b0;
                    dout_vld <= 1'b0;
                    busy     <= 1'b0;
                    state    <= S_IDLE;
                end
            endcase
        end
    end

endmodule
